// File: rtl/fetch_unit.sv
// Instruction-fetch controller: drives the next PC, issues single-outstanding
// instruction-memory requests and owns the IF/ID output register.
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int PC_INC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pend_pc;
  logic              buf_free;
  logic              advance;
  logic              load;

  assign buf_free  = !if_valid || !stall;
  assign advance   = imem_req && imem_gnt;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ:  if (advance) state_next = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)   state_next = S_REQ;
        else if (redirect) state_next = S_DROP;
      end
      S_DROP: if (imem_rvalid) state_next = S_REQ;
      default: state_next = S_IDLE;
    endcase
  end

  // A redirect suppresses the request so the stale PC is never fetched.
  always_comb begin
    imem_req = 1'b0;
    load     = 1'b0;
    case (state)
      S_REQ:   imem_req = buf_free && !redirect;
      S_WAIT:  load     = imem_rvalid && !redirect;
      default: ;
    endcase
  end

  always_comb begin
    if (redirect) begin
      npc = redirect_target & ALIGN_MASK;
    end else if (advance) begin
      npc = pc + PC_STEP;
    end else begin
      npc = pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_pc <= '0;
    end else if (advance) begin
      pend_pc <= pc;
    end
  end

  // Flush wins over everything; a load also covers a same-cycle consume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (load) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= pend_pc;
    end else if (if_valid && !stall) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .PC_INC(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .npc             (npc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .stall           (stall),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one fetch may be in flight; a redirect while in flight marks it
  // to be thrown away; the IF/ID buffer holds at most one instruction.
  bit          m_started;
  bit          m_out;
  bit          m_disc;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_pend;
  logic        e_req;
  logic [31:0] e_npc;
  bit          e_load;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_started = 0; m_out = 0; m_disc = 0; m_valid = 0;
        m_instr = 0; m_ipc = 0; m_pend = 0;
      end else begin
        e_req = m_started && !m_out && (!m_valid || !stall) && !redirect;
        if (redirect)              e_npc = redirect_target & 32'hFFFF_FFFC;
        else if (e_req && imem_gnt) e_npc = pc + 32'd4;
        else                       e_npc = pc;
        check("m_req",   32'(imem_req), 32'(e_req));
        check("m_addr",  imem_addr, pc);
        check("m_npc",   npc, e_npc);
        check("m_valid", 32'(if_valid), 32'(m_valid));
        if (m_valid) begin
          check("m_instr", if_instr, m_instr);
          check("m_ifpc",  if_pc, m_ipc);
        end
        e_load = 0;
        if (m_out && imem_rvalid) begin
          e_load = !m_disc && !redirect;
          m_out  = 0;
          m_disc = 0;
        end else if (m_out && redirect) begin
          m_disc = 1;
        end
        if (redirect) m_valid = 0;
        else if (e_load) begin
          m_valid = 1; m_instr = imem_rdata; m_ipc = m_pend;
        end else if (!stall) m_valid = 0;
        if (e_req && imem_gnt) begin
          m_out  = 1;
          m_pend = pc;
        end
        m_started = 1;
      end
    end
  end

  // The bench plays the PC register: pc takes npc at every rising edge.
  bit last_grant;
  task automatic tick();
    logic [31:0] n;
    @(negedge clk);
    n          = npc;
    last_grant = imem_req && imem_gnt;
    @(posedge clk);
    #1;
    pc = n;
  endtask

  bit busy;
  int dly;

  initial begin
    reset = 0; pc = 0; redirect = 0; redirect_target = 0; stall = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 32'(if_valid), 0);
    check("rst_instr", if_instr, 0);
    check("rst_ifpc",  if_pc, 0);
    check("rst_req",   32'(imem_req), 0);
    check("rst_npc",   npc, 32'h0);

    @(posedge clk); #1; reset = 1; imem_gnt = 1;
    #1 check("idle_req", 32'(imem_req), 0);
    tick(); #1;
    check("first_req",  32'(imem_req), 1);
    check("first_addr", imem_addr, 32'h0);
    check("first_npc",  npc, 32'h4);
    tick(); imem_rvalid = 1; imem_rdata = 32'h2008_0005; #1;
    check("wait_req", 32'(imem_req), 0);
    tick(); imem_rvalid = 0; redirect = 1; redirect_target = 32'h40; #1;
    check("lat_valid", 32'(if_valid), 1);
    check("lat_instr", if_instr, 32'h2008_0005);
    check("lat_ifpc",  if_pc, 32'h0);
    check("redir_npc", npc, 32'h40);
    tick(); redirect = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      imem_gnt = (k == 3);
      #1;
      if (k == 0) check("flush_valid", 32'(if_valid), 0);
      check("dly_req",  32'(imem_req), 1);
      check("dly_addr", imem_addr, 32'h40);
      check("dly_npc",  npc, (k == 3) ? 32'h44 : 32'h40);
    end
    tick(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hAAAA_0001;
    tick(); imem_rvalid = 0; stall = 1; imem_gnt = 1; #1;
    check("stall_valid", 32'(if_valid), 1);
    check("stall_ifpc",  if_pc, 32'h40);
    check("stall_req",   32'(imem_req), 0);
    check("stall_npc",   npc, 32'h44);
    tick(); #1;
    check("hold_ifpc",  if_pc, 32'h40);
    check("hold_instr", if_instr, 32'hAAAA_0001);
    check("hold_req",   32'(imem_req), 0);
    tick(); stall = 0; #1;
    check("unstall_req", 32'(imem_req), 1);
    check("unstall_npc", npc, 32'h48);
    tick(); imem_gnt = 0; redirect = 1; redirect_target = 32'h103; #1;
    check("consumed",  32'(if_valid), 0);
    check("align_npc", npc, 32'h100);
    check("wredir_req", 32'(imem_req), 0);
    tick(); redirect = 0; #1;
    check("drop_req", 32'(imem_req), 0);
    check("drop_npc", npc, 32'h100);
    tick(); imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; #1;
    check("drop_rsp_req", 32'(imem_req), 0);
    tick(); imem_rvalid = 0; imem_gnt = 1; #1;
    check("drop_discard", 32'(if_valid), 0);
    check("refetch_addr", imem_addr, 32'h100);
    check("refetch_npc",  npc, 32'h104);
    tick(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h5555; redirect = 1; redirect_target = 32'h200; #1;
    check("coinc_req", 32'(imem_req), 0);
    check("coinc_npc", npc, 32'h200);
    tick(); imem_rvalid = 0; imem_gnt = 1; redirect_target = 32'h300; #1;
    check("coinc_discard", 32'(if_valid), 0);
    check("reqredir_req",  32'(imem_req), 0);
    check("reqredir_npc",  npc, 32'h300);
    tick(); redirect = 0; #1;
    check("after_redir_req",  32'(imem_req), 1);
    check("after_redir_addr", imem_addr, 32'h300);
    tick(); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1234;
    tick(); imem_rvalid = 0; redirect = 1; redirect_target = 32'hFFFF_FFFE; #1;
    check("pre_wrap_ifpc", if_pc, 32'h300);
    check("pre_wrap_npc",  npc, 32'hFFFF_FFFC);
    tick(); redirect = 0; imem_gnt = 1; #1;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_npc",  npc, 32'h0);
    tick(); imem_gnt = 0; #1;
    check("wait2_req", 32'(imem_req), 0);
    reset = 0; pc = 32'h500; #1;
    check("async_valid", 32'(if_valid), 0);
    check("async_instr", if_instr, 0);
    check("async_ifpc",  if_pc, 0);
    check("async_req",   32'(imem_req), 0);
    check("async_npc",   npc, 32'h500);
    @(posedge clk); #1; reset = 1; pc = 32'h1000; #1;
    check("post_reset_idle", 32'(imem_req), 0);

    busy = 0; dly = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      imem_rvalid = 0;
      if (last_grant) begin
        busy = 1;
        dly  = $urandom_range(0, 2);
      end
      if (busy) begin
        if (dly == 0) begin
          imem_rvalid = 1;
          imem_rdata  = $urandom;
          busy        = 0;
        end else begin
          dly--;
        end
      end
      imem_gnt        = ($urandom_range(0, 9) < 6);
      stall           = ($urandom_range(0, 9) < 3);
      redirect        = ($urandom_range(0, 19) == 0);
      redirect_target = $urandom;
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "timeout");
  end

endmodule
